instr_mem_responder: RTL

// - Memory-side responder for the core instruction-fetch port: answers instr_req/instr_addr from the prefetcher with

---
 rtl/instr_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: address phase with programmable grant delay,
// in-order pipelined responses with fixed latency, backdoor-loadable word RAM.
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        protocol_err_o
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(GNT_DELAY + 2);
  localparam int LW = $clog2(RVALID_LATENCY + 1);
  localparam int QW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] f_word, l_word, f_data;
  logic        f_hit, l_hit;

  // Subtraction wraps addresses below BASE_ADDR to huge indices, so one compare covers both sides.
  assign f_word = (instr_addr_i - BASE_ADDR) >> 2;
  assign l_word = (load_addr_i - BASE_ADDR) >> 2;
  assign f_hit  = f_word < 32'(MEM_WORDS);
  assign l_hit  = l_word < 32'(MEM_WORDS);
  assign f_data = f_hit ? mem[f_word[AW-1:0]] : NOP;

  always_ff @(posedge clk) begin
    if (load_we_i && l_hit) mem[l_word[AW-1:0]] <= load_wdata_i;
  end

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, err_q;
  logic [31:0]   addr_q, last_q;
  logic [QW-1:0] count_q, count_d, wr_idx;
  logic [MAX_OUTSTANDING-1:0][31:0]   qdata_q, qdata_d;
  logic [MAX_OUTSTANDING-1:0][LW-1:0] qcnt_q, qcnt_d, qdec;
  logic          gnt, rvalid, viol;

  assign gnt = !rst && instr_req_i && count_q < QW'(MAX_OUTSTANDING) &&
               (GNT_DELAY == 0 || (state_q == S_WAIT && cnt_q == CW'(GNT_DELAY)));
  assign rvalid = (count_q != '0) && (qcnt_q[0] == '0);
  assign viol   = pend_q && (!instr_req_i || instr_addr_i != addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (gnt || viol || !instr_req_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (GNT_DELAY != 0) begin
      state_d = S_WAIT;
      if (cnt_q != CW'(GNT_DELAY)) cnt_d = cnt_q + 1'b1;
    end
  end

  // Countdowns age every cycle; a pop shifts the whole queue down and the push lands behind it.
  always_comb begin
    qdata_d = qdata_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      qdec[i] = (qcnt_q[i] != '0) ? qcnt_q[i] - 1'b1 : qcnt_q[i];
    qcnt_d = qdec;
    if (rvalid) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
        qdata_d[i] = qdata_q[i+1];
        qcnt_d[i]  = qdec[i+1];
      end
    end
    wr_idx = count_q - QW'(rvalid);
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (gnt && QW'(i) == wr_idx) begin
        qdata_d[i] = f_data;
        qcnt_d[i]  = LW'(RVALID_LATENCY - 1);
      end
    end
    count_d = count_q + QW'(gnt) - QW'(rvalid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= '0;
      count_q <= '0;
      qdata_q <= '0;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= instr_req_i && !gnt;
      addr_q  <= instr_addr_i;
      err_q   <= err_q | viol;
      if (rvalid) last_q <= qdata_q[0];
      count_q <= count_d;
      qdata_q <= qdata_d;
      qcnt_q  <= qcnt_d;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? qdata_q[0] : last_q;
  assign protocol_err_o = err_q;
endmodule
